// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
package prog_loader_pkg;

   // Machine-code word width used when the top level is not overridden.
   localparam int W_DEFAULT = 9;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      BOOT  = 3'd3,
      RUN   = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage : prog_loader_pkg

// File: rtl/prog_loader.sv
// Program loader: receives a machine-code stream, writes it into the
// external instruction memory, verifies a trailing checksum, then holds the
// core in reset for two boot cycles before releasing it to run.
// DEPTH must not exceed 2**D so that every loadable address fits in D bits.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int D     = 12,
   parameter int DEPTH = 128,
   parameter int W     = W_DEFAULT
) (
   input  logic         clk,
   input  logic         start,
   input  logic         load_req,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         mem_wr_en,
   output logic [D-1:0] mem_wr_addr,
   output logic [W-1:0] mem_wr_data,
   output logic         core_rst,
   input  logic         core_done,
   output logic         busy,
   output logic         err,
   output logic [D:0]   prog_len
);

   // count needs D+1 bits so that it can reach DEPTH when DEPTH == 2**D.
   localparam logic [D:0] DEPTH_L = (D+1)'(DEPTH);
   localparam logic [D:0] ONE_L   = (D+1)'(1);

   state_t         state;
   state_t         state_next;
   logic [D:0]     count;
   logic [W-1:0]   sum;
   logic           boot_cnt;

   logic           accept;
   logic           do_write;
   logic           do_clear;
   logic           do_len;

   assign accept = in_valid && in_ready;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register updates from the values seen before the edge.
      if (start) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus status outputs and datapath strobes.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_next = state;
      in_ready   = 1'b0;
      core_rst   = 1'b1;
      busy       = 1'b0;
      err        = 1'b0;
      do_write   = 1'b0;
      do_clear   = 1'b0;
      do_len     = 1'b0;

      case (state)
         IDLE: begin
            if (load_req) begin
               do_clear   = 1'b1;
               state_next = LOAD;
            end
         end

         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept) begin
               // A full memory rejects the beat regardless of in_last.
               if (count == DEPTH_L) begin
                  state_next = ERR;
               end else begin
                  do_write = 1'b1;
                  if (in_last) begin
                     state_next = CHECK;
                  end
               end
            end
         end

         CHECK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            // The beat here is the checksum; in_last carries no meaning.
            if (accept) begin
               if (in_data == sum) begin
                  do_len     = 1'b1;
                  state_next = BOOT;
               end else begin
                  state_next = ERR;
               end
            end
         end

         BOOT: begin
            busy = 1'b1;
            if (boot_cnt) begin
               state_next = RUN;
            end
         end

         RUN: begin
            core_rst = 1'b0;
            if (core_done) begin
               state_next = IDLE;
            end
         end

         ERR: begin
            err = 1'b1;
            if (load_req) begin
               do_clear   = 1'b1;
               state_next = LOAD;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: write port, beat counter, running checksum, boot timer and
   // latched program length.
   always_ff @(posedge clk) begin
      if (start) begin
         count       <= '0;
         sum         <= '0;
         boot_cnt    <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         prog_len    <= '0;
      end else begin
         mem_wr_en <= do_write;
         if (do_write) begin
            mem_wr_addr <= count[D-1:0];
            mem_wr_data <= in_data;
            count       <= count + ONE_L;
            sum         <= sum + in_data;
         end
         if (do_clear) begin
            count <= '0;
            sum   <= '0;
         end
         if (do_len) begin
            prog_len <= count;
         end
         // Boot timer: 0 in the first BOOT cycle, 1 in the second.
         boot_cnt <= (state == BOOT) && !boot_cnt;
      end
   end

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (DEPTH=128 and DEPTH=4)
// share one stimulus stream; expected writes are queued per instance and
// popped by monitors whenever an instance presents mem_wr_en.
module tb_prog_loader;

   localparam int D  = 12;
   localparam int W  = 9;

   typedef struct {
      logic [D-1:0] addr;
      logic [W-1:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         start;
   logic         load_req;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         core_done;

   logic         in_ready_a,  in_ready_b;
   logic         wr_en_a,     wr_en_b;
   logic [D-1:0] wr_addr_a,   wr_addr_b;
   logic [W-1:0] wr_data_a,   wr_data_b;
   logic         core_rst_a,  core_rst_b;
   logic         busy_a,      busy_b;
   logic         err_a,       err_b;
   logic [D:0]   prog_len_a,  prog_len_b;

   int errors = 0;
   int checks = 0;

   wr_t exp_a[$];
   wr_t exp_b[$];

   always #5 clk = ~clk;

   prog_loader #(.D(D), .DEPTH(128), .W(W)) dut_a (
      .clk(clk), .start(start), .load_req(load_req),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_a), .mem_wr_en(wr_en_a), .mem_wr_addr(wr_addr_a),
      .mem_wr_data(wr_data_a), .core_rst(core_rst_a), .core_done(core_done),
      .busy(busy_a), .err(err_a), .prog_len(prog_len_a)
   );

   prog_loader #(.D(D), .DEPTH(4), .W(W)) dut_b (
      .clk(clk), .start(start), .load_req(load_req),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_b), .mem_wr_en(wr_en_b), .mem_wr_addr(wr_addr_b),
      .mem_wr_data(wr_data_b), .core_rst(core_rst_b), .core_done(core_done),
      .busy(busy_b), .err(err_b), .prog_len(prog_len_b)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the DEPTH=128 instance.
   always @(negedge clk) begin
      if (wr_en_a === 1'b1) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_a_unexpected: got write addr=%0h data=%0h, expected none",
                     wr_addr_a, wr_data_a);
         end else begin
            wr_t e;
            e = exp_a.pop_front();
            check("wr_a_addr", 32'(wr_addr_a), 32'(e.addr));
            check("wr_a_data", 32'(wr_data_a), 32'(e.data));
         end
      end
   end

   // Monitor for the DEPTH=4 instance.
   always @(negedge clk) begin
      if (wr_en_b === 1'b1) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_b_unexpected: got write addr=%0h data=%0h, expected none",
                     wr_addr_b, wr_data_b);
         end else begin
            wr_t e;
            e = exp_b.pop_front();
            check("wr_b_addr", 32'(wr_addr_b), 32'(e.addr));
            check("wr_b_data", 32'(wr_data_b), 32'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit to_a, input bit to_b,
                       input logic [D-1:0] a, input logic [W-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      if (to_a) exp_a.push_back(e);
      if (to_b) exp_b.push_back(e);
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic send_prog3();
      push(1, 1, 12'd0, 9'h1A0);
      send_beat(9'h1A0, 1'b0);
      push(1, 1, 12'd1, 9'h005);
      send_beat(9'h005, 1'b0);
      push(1, 1, 12'd2, 9'h1FF);
      send_beat(9'h1FF, 1'b1);
   endtask

   initial begin
      start     = 1'b1;
      load_req  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      core_done = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_in_ready",  32'(in_ready_a), 0);
      check("rst_wr_en",     32'(wr_en_a),    0);
      check("rst_wr_addr",   32'(wr_addr_a),  0);
      check("rst_wr_data",   32'(wr_data_a),  0);
      check("rst_core_rst",  32'(core_rst_a), 1);
      check("rst_busy",      32'(busy_a),     0);
      check("rst_err",       32'(err_a),      0);
      check("rst_prog_len",  32'(prog_len_a), 0);
      start = 1'b0;
      tick();

      // Good 3-beat load, checksum 0x1A4, two BOOT cycles, then RUN
      pulse_load();
      check("load_ready", 32'(in_ready_a), 1);
      check("load_busy",  32'(busy_a),     1);
      send_prog3();
      check("check_ready", 32'(in_ready_b), 1);
      send_beat(9'h1A4, 1'b0);
      check("boot1_core_rst", 32'(core_rst_a), 1);
      check("boot1_busy",     32'(busy_a),     1);
      check("boot1_ready",    32'(in_ready_a), 0);
      tick();
      check("boot2_core_rst", 32'(core_rst_a), 1);
      check("boot2_busy",     32'(busy_a),     1);
      tick();
      check("run_core_rst_a", 32'(core_rst_a), 0);
      check("run_core_rst_b", 32'(core_rst_b), 0);
      check("run_busy",       32'(busy_a),     0);
      check("run_prog_len_a", 32'(prog_len_a), 3);
      check("run_prog_len_b", 32'(prog_len_b), 3);

      // load_req is ignored in RUN; core_done returns to IDLE
      pulse_load();
      check("run_ignores_load", 32'(core_rst_a), 0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("done_core_rst", 32'(core_rst_a), 1);
      check("done_busy",     32'(busy_a),     0);
      check("done_ready",    32'(in_ready_a), 0);

      // Reload from address 0, then a wrong checksum drives ERR
      pulse_load();
      send_prog3();
      send_beat(9'h000, 1'b0);
      check("bad_err_a",      32'(err_a),      1);
      check("bad_err_b",      32'(err_b),      1);
      check("bad_core_rst",   32'(core_rst_a), 1);
      check("bad_prog_len",   32'(prog_len_a), 3);
      tick();
      check("err_holds",      32'(err_a),      1);
      pulse_load();
      check("err_reload_err",   32'(err_a),      0);
      check("err_reload_ready", 32'(in_ready_a), 1);

      // in_valid toggled every other cycle: 4 beats, contiguous addresses
      for (int i = 0; i < 4; i++) begin
         push(1, 1, 12'(i), 9'(16 * (i + 1)));
         send_beat(9'(16 * (i + 1)), 1'(i == 3));
         if (i < 3) tick();
      end
      send_beat(9'h0A0, 1'b0);
      tick();
      tick();
      check("toggle_prog_len_a", 32'(prog_len_a), 4);
      check("toggle_prog_len_b", 32'(prog_len_b), 4);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;

      // start pulsed after 2 of 4 beats: load aborted, third beat dropped
      pulse_load();
      push(1, 1, 12'd0, 9'h101);
      send_beat(9'h101, 1'b0);
      push(1, 1, 12'd1, 9'h102);
      in_valid = 1'b1;
      in_data  = 9'h102;
      tick();
      in_data  = 9'h103;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      in_data  = 9'h104;
      check("abort_wr_en",    32'(wr_en_a),    0);
      check("abort_core_rst", 32'(core_rst_a), 1);
      check("abort_err",      32'(err_a),      0);
      check("abort_busy",     32'(busy_a),     0);
      check("abort_ready",    32'(in_ready_a), 0);
      tick();
      tick();
      in_valid = 1'b0;
      tick();

      // 5 beats without in_last: DEPTH=4 instance writes 4 then errors
      pulse_load();
      for (int i = 0; i < 5; i++) begin
         push(1'b1, 1'(i < 4), 12'(i), 9'(i + 1));
         send_beat(9'(i + 1), 1'b0);
      end
      check("ovf_err_b",   32'(err_b),      1);
      check("ovf_ready_b", 32'(in_ready_b), 0);
      check("ovf_err_a",   32'(err_a),      0);
      check("ovf_busy_a",  32'(busy_a),     1);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();

      check("drained_a", 32'(exp_a.size()), 0);
      check("drained_b", 32'(exp_b.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_prog_loader
